// File: rtl/rx_crc_pkg.sv
// Shared constants, FSM encoding and helpers for the rx CRC controller.
package rx_crc_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CRC_W  = 32;

  localparam logic [CRC_W-1:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [CRC_W-1:0] CRC_RESIDUE = 32'hC704_DD7B;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_CHECK = 2'd3
  } state_t;

  // Per-frame status flags reported alongside FRAME_DONE.
  typedef struct packed {
    logic crc_ok;
    logic len_err;
    logic abort;
  } frame_stat_t;

  // Wire-order byte to MSB-first engine order: result = {b0, b1, ..., b7}.
  function automatic logic [BYTE_W-1:0] byte_rev(input logic [BYTE_W-1:0] b);
    return {b[0], b[1], b[2], b[3], b[4], b[5], b[6], b[7]};
  endfunction

endpackage

// File: rtl/rx_fcs_strip.sv
// Four-byte delay line that drops the trailing FCS and moves EOF onto the last payload byte.
module rx_fcs_strip
  import rx_crc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              last,
  input  logic              flush,
  input  logic [BYTE_W-1:0] data,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_eof
);

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 3;

  logic [DEPTH-1:0][BYTE_W-1:0] line_q;
  logic [CNT_W-1:0]             cnt_q;
  logic                         full;

  assign full = (cnt_q == CNT_W'(DEPTH));

  // Shift bytes in; once four are held, each new byte releases the oldest one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q    <= '0;
      cnt_q     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_eof   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_eof   <= 1'b0;
      if (push) begin
        line_q <= {line_q[DEPTH-2:0], data};
      end
      if (flush) begin
        cnt_q <= (push && !last) ? CNT_W'(1) : '0;
      end else if (push) begin
        if (full) begin
          out_valid <= 1'b1;
          out_data  <= line_q[DEPTH-1];
          out_eof   <= last;
        end
        if (last) begin
          cnt_q <= '0;
        end else if (!full) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/rx_crc_ctrl.sv
// Sequences a byte-wide CRC32 engine over one rx frame, counts its length and reports status.
// Optional feature: define RX_CRC_STRIP_EN to strip the FCS from the forwarded byte stream.
module rx_crc_ctrl
  import rx_crc_pkg::*;
#(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1518,
  parameter int unsigned LEN_W   = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              rx_sof,
  input  logic              rx_eof,
  output logic              crc_load,
  output logic              crc_start,
  output logic [CRC_W-1:0]  crc_seed,
  output logic [BYTE_W-1:0] crc_data,
  input  logic [CRC_W-1:0]  crc_result,
  output logic              frame_done,
  output logic              crc_ok,
  output logic              len_err,
  output logic              abort,
  output logic              drop,
  output logic [LEN_W-1:0]  frame_len,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_eof
);

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d, len_inc;
  logic [LEN_W-1:0]  frame_len_q, frame_len_d;
  frame_stat_t       stat_q, stat_d;
  logic              done_q, done_d;
  logic              drop_q, drop_d;
  logic              in_valid_q;
  logic [BYTE_W-1:0] in_data_q;
  logic [CRC_W-1:0]  seed_q;
  logic              accept;
  logic              sof_v;

  function automatic logic len_bad(input logic [LEN_W-1:0] n);
    return (n < LEN_W'(MIN_LEN)) || (n > LEN_W'(MAX_LEN));
  endfunction

  assign sof_v   = rx_valid & rx_sof;
  assign len_inc = (&len_q) ? len_q : len_q + LEN_W'(1);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, engine LOAD, byte acceptance and frame status.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    frame_len_d = frame_len_q;
    stat_d      = '0;
    done_d      = 1'b0;
    drop_d      = 1'b0;
    crc_load    = 1'b0;
    accept      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sof_v) begin
          crc_load = 1'b1;
          accept   = 1'b1;
          len_d    = LEN_W'(1);
          state_d  = rx_eof ? ST_FLUSH : ST_RUN;
        end
      end
      ST_RUN: begin
        if (rx_valid) begin
          accept = 1'b1;
          if (rx_sof) begin
            // Frame cut short by a new SOF: report it and restart on this byte.
            crc_load       = 1'b1;
            done_d         = 1'b1;
            stat_d.abort   = 1'b1;
            stat_d.len_err = len_bad(len_q);
            frame_len_d    = len_q;
            len_d          = LEN_W'(1);
          end else begin
            len_d = len_inc;
          end
          if (rx_eof) begin
            state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        drop_d  = sof_v;
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        drop_d         = sof_v;
        done_d         = 1'b1;
        stat_d.crc_ok  = (crc_result == CRC_RESIDUE) && (len_q != LEN_W'(1));
        stat_d.len_err = len_bad(len_q);
        frame_len_d    = len_q;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Input stage, length counter and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q       <= '0;
      frame_len_q <= '0;
      stat_q      <= '0;
      done_q      <= 1'b0;
      drop_q      <= 1'b0;
      in_valid_q  <= 1'b0;
      in_data_q   <= '0;
      seed_q      <= '0;
    end else begin
      len_q       <= len_d;
      frame_len_q <= frame_len_d;
      stat_q      <= stat_d;
      done_q      <= done_d;
      drop_q      <= drop_d;
      in_valid_q  <= accept;
      seed_q      <= CRC_INIT;
      if (accept) begin
        in_data_q <= rx_data;
      end
    end
  end

  // A START that coincides with a restart LOAD belongs to the aborted frame and is dropped.
  assign crc_start  = in_valid_q & ~crc_load;
  assign crc_data   = byte_rev(in_data_q);
  assign crc_seed   = seed_q;
  assign frame_done = done_q;
  assign crc_ok     = stat_q.crc_ok;
  assign len_err    = stat_q.len_err;
  assign abort      = stat_q.abort;
  assign drop       = drop_q;
  assign frame_len  = frame_len_q;

`ifdef RX_CRC_STRIP_EN
  logic strip_flush;

  assign strip_flush = ((state_q == ST_RUN) && sof_v) || drop_d;

  rx_fcs_strip u_strip (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept),
    .last      (rx_eof),
    .flush     (strip_flush),
    .data      (rx_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_eof   (out_eof)
  );
`else
  logic in_eof_q;

  // EOF flag of the registered input byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_eof_q <= 1'b0;
    end else begin
      in_eof_q <= accept & rx_eof;
    end
  end

  assign out_valid = in_valid_q;
  assign out_data  = in_data_q;
  assign out_eof   = in_eof_q;
`endif

endmodule

// File: tb/tb_rx_crc_ctrl.sv
// Bench for rx_crc_ctrl with a behavioural byte-wide CRC32 engine and a frame-status scoreboard.
module tb_rx_crc_ctrl;
  import rx_crc_pkg::*;

  localparam int unsigned LEN_W = 14;

  logic              clk;
  logic              rst_n;
  logic [7:0]        rx_data;
  logic              rx_valid, rx_sof, rx_eof;
  logic              crc_load, crc_start;
  logic [31:0]       crc_seed, crc_result;
  logic [7:0]        crc_data;
  logic              frame_done, crc_ok, len_err, abort, drop;
  logic [LEN_W-1:0]  frame_len;
  logic [7:0]        out_data;
  logic              out_valid, out_eof;

  rx_crc_ctrl #(.MIN_LEN(64), .MAX_LEN(1518), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid), .rx_sof(rx_sof),
    .rx_eof(rx_eof), .crc_load(crc_load), .crc_start(crc_start), .crc_seed(crc_seed),
    .crc_data(crc_data), .crc_result(crc_result), .frame_done(frame_done), .crc_ok(crc_ok),
    .len_err(len_err), .abort(abort), .drop(drop), .frame_len(frame_len),
    .out_data(out_data), .out_valid(out_valid), .out_eof(out_eof)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CRC32 engine: LOAD takes CRC_IN, START folds DATA_IN in MSB first (poly 04C11DB7).
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[31] ^ d[i]) r = (r << 1) ^ 32'h04C1_1DB7;
      else              r = r << 1;
    end
    return r;
  endfunction

  logic [31:0] eng_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         eng_q <= '0;
    else if (crc_load)  eng_q <= crc_seed;
    else if (crc_start) eng_q <= crc_step(eng_q, crc_data);
  end
  assign crc_result = eng_q;

  typedef struct packed {
    logic [31:0]      cyc;
    logic             abort;
    logic             lerr;
    logic             ok;
    logic [LEN_W-1:0] len;
  } stat_t;

  stat_t      exp_q[$];
  stat_t      obs_q[$];
  logic [7:0] frm[$];
  logic [7:0] out_q[$];

  int cyc = 0;
  int vec = 0;
  int miss = 0;
  int n_start = 0, n_load = 0, n_both = 0, n_drop = 0, n_oeof = 0;
  int last_load_cyc = -1, last_drop_cyc = -1, oeof_pos = -1;

  function automatic stat_t mk(input int c, input logic ab, input logic le, input logic ok, input int n);
    stat_t s;
    s.cyc = 32'(c); s.abort = ab; s.lerr = le; s.ok = ok; s.len = LEN_W'(n);
    return s;
  endfunction

  function automatic string fmt(input stat_t s);
    return $sformatf("cyc=%0d abort=%b len_err=%b crc_ok=%b len=%0d", s.cyc, s.abort, s.lerr, s.ok, s.len);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (frame_done) obs_q.push_back(mk(cyc, abort, len_err, crc_ok, int'(frame_len)));
    if (crc_start) n_start++;
    if (crc_load) begin n_load++; last_load_cyc = cyc; end
    if (crc_load && crc_start) n_both++;
    if (drop) begin n_drop++; last_drop_cyc = cyc; end
    if (out_valid) begin
      out_q.push_back(out_data);
      if (out_eof) begin n_oeof++; oeof_pos = out_q.size(); end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Payload of n-4 random bytes plus Ethernet FCS (reflected CRC32, complemented, LSB byte first).
  task automatic build_frame(input int n, input int flip);
    logic [31:0] c;
    logic [7:0]  b;
    frm.delete();
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n - 4; i++) begin
      b = 8'($urandom);
      frm.push_back(b);
      c = c ^ {24'h0, b};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    c = ~c;
    frm.push_back(c[7:0]);
    frm.push_back(c[15:8]);
    frm.push_back(c[23:16]);
    frm.push_back(c[31:24]);
    if (flip >= 0) frm[flip] = frm[flip] ^ 8'h08;
  endtask

  task automatic drive_idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0; rx_data = 8'h00;
    end
  endtask

  task automatic send(input int nbytes, input bit with_eof, input bit toggle, output int t_sof, output int t_eof);
    t_sof = -1;
    t_eof = -1;
    for (int i = 0; i < nbytes; i++) begin
      @(posedge clk); #1;
      rx_valid = 1'b1; rx_data = frm[i];
      rx_sof = (i == 0);
      rx_eof = with_eof && (i == nbytes - 1);
      if (i == 0) t_sof = cyc;
      t_eof = cyc;
      if (toggle && i != nbytes - 1) begin
        @(posedge clk); #1;
        rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0;
      end
    end
  endtask

  task automatic wait_obs(input int n);
    for (int k = 0; k < 100 && obs_q.size() < n; k++) @(posedge clk);
  endtask

  task automatic test_reset();
    logic [70:0] snap;
    rst_n = 1'b0; rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    snap = {crc_load, crc_start, crc_seed, crc_data, frame_done, crc_ok, len_err, abort, drop,
            frame_len, out_data, out_valid, out_eof};
    vec++;
    if (snap !== '0) begin miss++; $display("FAIL reset_outputs: got %h, want 0", snap); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive_idle(2);
    vec++;
    if (crc_seed !== 32'hFFFF_FFFF) begin miss++; $display("FAIL seed: got %h, want ffffffff", crc_seed); end
  endtask

  task automatic test_good_frame();
    int ts, te, l0, s0;
    stat_t e, o;
    build_frame(64, -1);
    l0 = n_load; s0 = n_start;
    send(64, 1'b1, 1'b0, ts, te);
    exp_q.push_back(mk(te + 3, 1'b0, 1'b0, 1'b1, 64));
    drive_idle(6);
    wait_obs(exp_q.size());
    vec++;
    if (n_load - l0 !== 1) begin miss++; $display("FAIL good_load_count: got %0d, want 1", n_load - l0); end
    vec++;
    if (last_load_cyc !== ts) begin miss++; $display("FAIL good_load_cycle: got %0d, want %0d", last_load_cyc, ts); end
    vec++;
    if (n_start - s0 !== 64) begin miss++; $display("FAIL good_start_count: got %0d, want 64", n_start - s0); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vec++;
      if (obs_q.size() == 0) begin miss++; $display("FAIL good_status: no FRAME_DONE, want %s", fmt(e)); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin miss++; $display("FAIL good_status: got %s, want %s", fmt(o), fmt(e)); end
      end
    end
  endtask

  task automatic test_crc_error();
    int ts, te;
    stat_t e, o;
    build_frame(64, 20);
    send(64, 1'b1, 1'b0, ts, te);
    exp_q.push_back(mk(te + 3, 1'b0, 1'b0, 1'b0, 64));
    drive_idle(6);
    wait_obs(exp_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vec++;
      if (obs_q.size() == 0) begin miss++; $display("FAIL crc_err_status: no FRAME_DONE, want %s", fmt(e)); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin miss++; $display("FAIL crc_err_status: got %s, want %s", fmt(o), fmt(e)); end
      end
    end
  endtask

  // Short, long, max-legal and single-byte frames separated by the minimum 2-cycle gap.
  task automatic test_length();
    int ts, te;
    int lens[3] = '{60, 1519, 1518};
    stat_t e, o;
    for (int k = 0; k < 3; k++) begin
      build_frame(lens[k], -1);
      send(lens[k], 1'b1, 1'b0, ts, te);
      exp_q.push_back(mk(te + 3, 1'b0, (lens[k] != 1518), 1'b1, lens[k]));
      drive_idle(2);
    end
    frm.delete();
    frm.push_back(8'h55);
    send(1, 1'b1, 1'b0, ts, te);
    exp_q.push_back(mk(te + 3, 1'b0, 1'b1, 1'b0, 1));
    drive_idle(6);
    wait_obs(exp_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vec++;
      if (obs_q.size() == 0) begin miss++; $display("FAIL length_status: no FRAME_DONE, want %s", fmt(e)); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin miss++; $display("FAIL length_status: got %s, want %s", fmt(o), fmt(e)); end
      end
    end
  endtask

  task automatic test_gaps();
    int ts, te, s0;
    stat_t e, o;
    build_frame(64, -1);
    s0 = n_start;
    send(64, 1'b1, 1'b1, ts, te);
    exp_q.push_back(mk(te + 3, 1'b0, 1'b0, 1'b1, 64));
    drive_idle(6);
    wait_obs(exp_q.size());
    vec++;
    if (n_start - s0 !== 64) begin miss++; $display("FAIL gap_start_count: got %0d, want 64", n_start - s0); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vec++;
      if (obs_q.size() == 0) begin miss++; $display("FAIL gap_status: no FRAME_DONE, want %s", fmt(e)); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin miss++; $display("FAIL gap_status: got %s, want %s", fmt(o), fmt(e)); end
      end
    end
  endtask

  task automatic test_abort_drop();
    int ts_a, te_a, ts_b, te_b, ts_c, te_c, ts_d, te_d, d0;
    stat_t e, o;
    build_frame(64, -1);
    send(30, 1'b0, 1'b0, ts_a, te_a);
    build_frame(64, -1);
    send(64, 1'b1, 1'b0, ts_b, te_b);
    exp_q.push_back(mk(ts_b + 1, 1'b1, 1'b1, 1'b0, 30));
    exp_q.push_back(mk(te_b + 3, 1'b0, 1'b0, 1'b1, 64));
    d0 = n_drop;
    build_frame(64, -1);
    send(64, 1'b1, 1'b0, ts_c, te_c);
    drive_idle(2);
    build_frame(64, -1);
    send(64, 1'b1, 1'b0, ts_d, te_d);
    exp_q.push_back(mk(te_d + 3, 1'b0, 1'b0, 1'b1, 64));
    drive_idle(6);
    wait_obs(exp_q.size());
    vec++;
    if (n_drop - d0 !== 1) begin miss++; $display("FAIL drop_count: got %0d, want 1", n_drop - d0); end
    vec++;
    if (last_drop_cyc !== te_b + 2) begin miss++; $display("FAIL drop_cycle: got %0d, want %0d", last_drop_cyc, te_b + 2); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vec++;
      if (obs_q.size() == 0) begin miss++; $display("FAIL abort_status: no FRAME_DONE, want %s", fmt(e)); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin miss++; $display("FAIL abort_status: got %s, want %s", fmt(o), fmt(e)); end
      end
    end
    vec++;
    if (obs_q.size() != 0) begin
      miss++; $display("FAIL abort_extra_done: got %0d extra FRAME_DONE, want 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_stream_reset();
    int ts, te, o0, e0, nexp, bad;
    logic [70:0] snap;
    stat_t e, o;
`ifdef RX_CRC_STRIP_EN
    nexp = 60;
`else
    nexp = 64;
`endif
    build_frame(64, -1);
    o0 = out_q.size(); e0 = n_oeof;
    send(64, 1'b1, 1'b0, ts, te);
    exp_q.push_back(mk(te + 3, 1'b0, 1'b0, 1'b1, 64));
    drive_idle(6);
    vec++;
    if (out_q.size() - o0 !== nexp) begin miss++; $display("FAIL stream_count: got %0d, want %0d", out_q.size() - o0, nexp); end
    vec++;
    if (n_oeof - e0 !== 1 || oeof_pos !== o0 + nexp) begin
      miss++; $display("FAIL stream_eof: got %0d eofs at byte %0d, want 1 at byte %0d", n_oeof - e0, oeof_pos - o0, nexp);
    end
    bad = 0;
    for (int i = 0; i < nexp; i++) if (o0 + i >= out_q.size() || out_q[o0 + i] !== frm[i]) bad++;
    vec++;
    if (bad !== 0) begin miss++; $display("FAIL stream_data: got %0d wrong bytes, want 0", bad); end

    // Reset in the middle of a frame: no status, then a clean restart.
    build_frame(64, -1);
    send(20, 1'b0, 1'b0, ts, te);
    #2;
    rst_n = 1'b0;
    #1;
    snap = {crc_load, crc_start, crc_seed, crc_data, frame_done, crc_ok, len_err, abort, drop,
            frame_len, out_data, out_valid, out_eof};
    vec++;
    if (snap !== '0) begin miss++; $display("FAIL midreset_outputs: got %h, want 0", snap); end
    rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive_idle(8);
    build_frame(64, -1);
    send(64, 1'b1, 1'b0, ts, te);
    exp_q.push_back(mk(te + 3, 1'b0, 1'b0, 1'b1, 64));
    drive_idle(6);
    wait_obs(exp_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vec++;
      if (obs_q.size() == 0) begin miss++; $display("FAIL stream_status: no FRAME_DONE, want %s", fmt(e)); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin miss++; $display("FAIL stream_status: got %s, want %s", fmt(o), fmt(e)); end
      end
    end
    vec++;
    if (obs_q.size() != 0) begin
      miss++; $display("FAIL midreset_extra_done: got %0d extra FRAME_DONE, want 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_strobes();
    vec++;
    if (n_both !== 0) begin miss++; $display("FAIL load_start_overlap: got %0d cycles, want 0", n_both); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_crc_error();
    test_length();
    test_gaps();
    test_abort_drop();
    test_stream_reset();
    test_strobes();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
